// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: shift-mode encodings and the
// per-stage record that travels down the pipe alongside the data.
package shifter_pkg;

    localparam int unsigned MaxW = 64;

    typedef enum logic [1:0] {
        ModeLsl = 2'b00,
        ModeLsr = 2'b01,
        ModeAsr = 2'b10,
        ModeRor = 2'b11
    } shMode_e;

    // data is sized for the widest supported datapath; narrower pipes use the low W bits
    typedef struct packed {
        logic [MaxW-1:0] data;
        logic            carry;
        shMode_e         mode;
        logic            valid;
    } stageRec_t;

endpackage

// File: rtl/shift_stage.sv
// One conditional shift by a fixed distance, with the matching carry update.
// Purely combinational; the enclosing pipe owns the registers.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned W    = 32,
    parameter int unsigned Dist = 1
) (
    input  logic [W-1:0] dataIn,
    input  logic         carryIn,
    input  shMode_e      mode,
    input  logic         doShift,
    output logic [W-1:0] dataOut,
    output logic         carryOut
);

    always_comb begin
        dataOut  = dataIn;
        carryOut = carryIn;
        if (doShift) begin
            unique case (mode)
                ModeLsl: begin
                    dataOut  = dataIn << Dist;
                    carryOut = dataIn[W-Dist];
                end
                ModeLsr: begin
                    dataOut  = dataIn >> Dist;
                    carryOut = dataIn[Dist-1];
                end
                ModeAsr: begin
                    dataOut  = $signed(dataIn) >>> Dist;
                    carryOut = dataIn[Dist-1];
                end
                ModeRor: begin
                    dataOut  = (dataIn >> Dist) | (dataIn << (W - Dist));
                    // bit rotated into the MSB
                    carryOut = dataIn[Dist-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: LOG2W registered stages, largest shift distance first,
// with a valid/ready handshake on both sides and a whole-pipe stall on backpressure.
module shift_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned LOG2W = $clog2(W)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [W-1:0]     ShIn,
    input  logic [LOG2W-1:0] Shamt,
    input  logic [1:0]       ShMode,
    input  logic             CarryIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [W-1:0]     ShOut,
    output logic             CarryOut
);

    logic stall;

    assign stall   = OutValid && !OutReady;
    assign InReady = !stall;

    for (genvar i = 0; i < LOG2W; i++) begin : genStage
        logic [W-1:0]     dataIn;
        logic [W-1:0]     dataOut;
        logic             carryIn;
        logic             carryOut;
        logic             validIn;
        logic             doShift;
        shMode_e          modeIn;
        logic [LOG2W-1:0] amtIn;
        stageRec_t        q;
        logic [LOG2W-1:0] amtQ;
        logic             unusedBits;

        if (i == 0) begin : genHead
            assign dataIn  = ShIn;
            assign carryIn = CarryIn;
            assign modeIn  = shMode_e'(ShMode);
            assign validIn = InValid;
            assign amtIn   = Shamt;
        end else begin : genBody
            assign dataIn  = genStage[i-1].q.data[W-1:0];
            assign carryIn = genStage[i-1].q.carry;
            assign modeIn  = genStage[i-1].q.mode;
            assign validIn = genStage[i-1].q.valid;
            assign amtIn   = genStage[i-1].amtQ;
        end

        assign doShift = amtIn[LOG2W-1-i];

        shift_stage #(
            .W    (W),
            .Dist (1 << (LOG2W - 1 - i))
        ) uShift (
            .dataIn   (dataIn),
            .carryIn  (carryIn),
            .mode     (modeIn),
            .doShift  (doShift),
            .dataOut  (dataOut),
            .carryOut (carryOut)
        );

        always_ff @(posedge CLK or posedge Reset) begin
            if (Reset) begin
                q    <= '0;
                amtQ <= '0;
            end else if (Flush) begin
                q.valid <= 1'b0;
            end else if (!stall) begin
                q    <= '{data: MaxW'(dataOut), carry: carryOut, mode: modeIn, valid: validIn};
                amtQ <= amtIn;
            end
        end

        // Upper data bits, spent shift-amount bits and the last stage's mode are never read
        assign unusedBits = ^{q, amtQ};
    end

    assign OutValid = genStage[LOG2W-1].q.valid;
    assign ShOut    = genStage[LOG2W-1].q.data[W-1:0];
    assign CarryOut = genStage[LOG2W-1].q.carry;

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (W=32): scoreboard of model results pushed on
// acceptance and popped on output transfer, plus directed latency/stall/reset/flush steps.
module tb_shift_pipe;

    logic        CLK = 1'b0;
    logic        Reset, Flush, InValid, InReady, CarryIn, OutValid, OutReady, CarryOut;
    logic [31:0] ShIn, ShOut;
    logic [4:0]  Shamt;
    logic [1:0]  ShMode;

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] sb[$];
    logic        holdValid = 1'b0;
    logic [32:0] holdVal;
    logic        accepted;

    shift_pipe #(.W(32)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Flush    (Flush),
        .InValid  (InValid),
        .InReady  (InReady),
        .ShIn     (ShIn),
        .Shamt    (Shamt),
        .ShMode   (ShMode),
        .CarryIn  (CarryIn),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .ShOut    (ShOut),
        .CarryOut (CarryOut)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [32:0] model(input logic [31:0] x, input int n,
                                          input logic [1:0] m, input logic cin);
        logic [31:0] r;
        logic        c;
        if (n == 0) return {cin, x};
        case (m)
            2'b00:   begin r = x << n; c = x[32-n]; end
            2'b01:   begin r = x >> n; c = x[n-1]; end
            2'b10:   begin r = 32'($signed(x) >>> n); c = x[n-1]; end
            default: begin r = (x >> n) | (x << (32 - n)); c = r[31]; end
        endcase
        return {c, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic randReq();
        ShIn    = $urandom();
        Shamt   = 5'($urandom_range(0, 31));
        ShMode  = 2'($urandom_range(0, 3));
        CarryIn = 1'($urandom_range(0, 1));
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge
    task automatic cycle();
        logic [32:0] exp;
        #1;
        if (OutValid && OutReady) begin
            if (sb.size() == 0) begin
                chk("spurious_out", OutValid, 0);
            end else begin
                exp = sb.pop_front();
                chk("out_data", ShOut, exp[31:0]);
                chk("out_carry", CarryOut, exp[32]);
            end
        end
        if (OutValid && !OutReady) begin
            if (holdValid) chk("stall_stable", {CarryOut, ShOut}, holdVal);
            holdValid = 1'b1;
            holdVal   = {CarryOut, ShOut};
        end else begin
            holdValid = 1'b0;
        end
        accepted = InValid && InReady;
        if (accepted && !Flush) sb.push_back(model(ShIn, int'(Shamt), ShMode, CarryIn));
        @(negedge CLK);
    endtask

    task automatic drain(input string tag);
        InValid  = 1'b0;
        OutReady = 1'b1;
        for (int k = 0; k < 40 && sb.size() != 0; k++) cycle();
        chk({tag, "_drained"}, sb.size(), 0);
    endtask

    task automatic issueLatency(input string tag, input logic [31:0] d, input logic [4:0] n,
                                input logic [1:0] m, input logic c);
        ShIn = d; Shamt = n; ShMode = m; CarryIn = c;
        InValid  = 1'b1;
        OutReady = 1'b1;
        cycle();
        InValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_early"}, OutValid, 0);
            cycle();
        end
        chk({tag, "_valid"}, OutValid, 1);
    endtask

    logic [31:0] dData [11] = '{32'h80000001, 32'h00000001, 32'h12345678, 32'h12345678,
                                32'h12345678, 32'h12345678, 32'h80000010, 32'h80000001,
                                32'h00000003, 32'h7fffffff, 32'h80000001};
    logic [4:0]  dAmt  [11] = '{5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd31, 5'd31,
                                5'd31, 5'd31};
    logic [1:0]  dMode [11] = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01,
                                2'b00, 2'b10, 2'b11};
    logic        dCin  [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b1, 1'b0};

    initial begin
        int sent;
        Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        ShIn = '0; Shamt = '0; ShMode = '0; CarryIn = 1'b0;

        // Reset state
        @(negedge CLK);
        #1;
        chk("rst_outvalid", OutValid, 0);
        chk("rst_shout", ShOut, 0);
        chk("rst_carry", CarryOut, 0);
        chk("rst_inready", InReady, 1);
        @(negedge CLK);
        Reset = 1'b0;

        // ASR example with exact latency
        issueLatency("asr", 32'h80000010, 5'd4, 2'b10, 1'b0);
        chk("asr_data", ShOut, 32'hF8000001);
        chk("asr_carry", CarryOut, 0);
        cycle();
        drain("asr");

        // Directed modes back-to-back, including shamt 0 and max shamt
        for (int k = 0; k < 11; k++) begin
            ShIn = dData[k]; Shamt = dAmt[k]; ShMode = dMode[k]; CarryIn = dCin[k];
            InValid = 1'b1;
            cycle();
        end
        drain("directed");

        // Eight back-to-back requests with OutReady low for cycles 6..9
        sent = 0;
        randReq();
        for (int c = 0; c < 60 && (sent < 8 || sb.size() != 0); c++) begin
            InValid  = (sent < 8);
            OutReady = !(c >= 6 && c <= 9);
            #1;
            chk("stall_inready", InReady, !(c >= 6 && c <= 9));
            cycle();
            if (accepted) begin
                sent++;
                randReq();
            end
        end
        chk("stall_sent", sent, 8);
        chk("stall_drained", sb.size(), 0);

        // Asynchronous reset with three requests in flight
        OutReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            randReq();
            InValid = 1'b1;
            cycle();
        end
        InValid = 1'b0;
        cycle();
        cycle();
        chk("arst_pre_valid", OutValid, 1);
        #2 Reset = 1'b1;
        #1;
        chk("arst_outvalid", OutValid, 0);
        chk("arst_shout", ShOut, 0);
        chk("arst_inready", InReady, 1);
        sb.delete();
        holdValid = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;
        issueLatency("arst_first", 32'h00000001, 5'd1, 2'b11, 1'b0);
        cycle();
        drain("arst");

        // Flush with four in flight and a simultaneous request
        OutReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            randReq();
            InValid = 1'b1;
            cycle();
        end
        randReq();
        Flush = 1'b1;
        cycle();
        Flush   = 1'b0;
        InValid = 1'b0;
        sb.delete();
        for (int k = 0; k < 6; k++) begin
            chk("flush_quiet", OutValid, 0);
            cycle();
        end
        issueLatency("flush_new", 32'h12345678, 5'd8, 2'b01, 1'b1);
        cycle();
        drain("flush");

        // Random traffic with random backpressure
        for (int k = 0; k < 40; k++) begin
            randReq();
            InValid  = ($urandom_range(0, 3) != 0);
            OutReady = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
